// File: rtl/ped_if.sv
// Signal bundle between the traffic-light controller side and the pedestrian stage.
// The master drives the lights and buttons; the slave drives the crosswalk outputs.
interface ped_if;
    logic [2:0] light_N;
    logic [2:0] light_E;
    logic [2:0] light_S;
    logic [2:0] light_W;
    logic [3:0] ped_req;
    logic [3:0] walk;
    logic [3:0] flash_dw;
    logic [3:0] req_pending;
    logic       fault;

    modport master (
        output light_N, light_E, light_S, light_W, ped_req,
        input  walk, flash_dw, req_pending, fault
    );

    modport slave (
        input  light_N, light_E, light_S, light_W, ped_req,
        output walk, flash_dw, req_pending, fault
    );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing stage: per-crosswalk DW -> WALK -> FLASH sequencing,
// granted on another approach's green onset while the crossed approach is red.
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 6,
    parameter int FLASH_CYCLES = 3
) (
    input logic clk,
    input logic rst,
    ped_if.slave bus
);

    typedef enum logic [1:0] {ST_DW, ST_WALK, ST_FLASH} state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYCLES - 1);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES - 1);

    logic [2:0] w_light [4];
    logic [3:0] w_red;
    logic [3:0] w_onset;
    logic [3:0] w_rise;
    logic [3:0] w_grant;
    logic       w_fault_det;

    logic [3:0] r_sync1, r_sync2, r_sync3;
    logic [3:0] r_pending;
    logic [3:0] r_walk;
    logic [3:0] r_flash;
    logic       r_fault;
    logic [2:0] r_prev  [4];
    state_t     r_state [4];
    logic [3:0] r_timer [4];

    assign w_light[0] = bus.light_N;
    assign w_light[1] = bus.light_E;
    assign w_light[2] = bus.light_S;
    assign w_light[3] = bus.light_W;

    // Third flop turns a synchronised level into a single-cycle rise.
    assign w_rise = r_sync2 & ~r_sync3;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_red       = '0;
        w_onset     = '0;
        w_grant     = '0;
        w_fault_det = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_red[i]   = (w_light[i] == RED);
            w_onset[i] = (w_light[i] == GRN) && (r_prev[i] != GRN);
            if (!(w_light[i] inside {RED, YEL, GRN}))
                w_fault_det = 1'b1;
            if ((r_state[i] != ST_DW) && !w_red[i])
                w_fault_det = 1'b1;
        end
        if ($countones(~w_red) > 1)
            w_fault_det = 1'b1;
        // A crosswalk is served only by a green onset on some other approach.
        for (int i = 0; i < 4; i++)
            w_grant[i] = r_pending[i] && w_red[i] && |(w_onset & ~(4'b0001 << i));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_pending <= '0;
            r_walk    <= '0;
            r_flash   <= '0;
            r_fault   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_prev[i]  <= RED;
                r_state[i] <= ST_DW;
                r_timer[i] <= '0;
            end
        end else begin
            r_sync1 <= bus.ped_req;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            for (int i = 0; i < 4; i++)
                r_prev[i] <= w_light[i];

            if (r_fault || w_fault_det) begin
                // Sticky: everything parks in DONT-WALK until reset.
                r_fault   <= 1'b1;
                r_pending <= '0;
                r_walk    <= '0;
                r_flash   <= '0;
                for (int i = 0; i < 4; i++) begin
                    r_state[i] <= ST_DW;
                    r_timer[i] <= '0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    case (r_state[i])
                        ST_DW: begin
                            if (w_grant[i]) begin
                                r_state[i]   <= ST_WALK;
                                r_timer[i]   <= WALK_LOAD;
                                r_walk[i]    <= 1'b1;
                                r_pending[i] <= 1'b0;
                            end else if (w_rise[i]) begin
                                r_pending[i] <= 1'b1;
                            end
                        end
                        ST_WALK: begin
                            // Presses during WALK are already being served.
                            if (r_timer[i] == 4'd0) begin
                                r_state[i] <= ST_FLASH;
                                r_timer[i] <= FLASH_LOAD;
                                r_walk[i]  <= 1'b0;
                                r_flash[i] <= 1'b1;
                            end else begin
                                r_timer[i] <= r_timer[i] - 4'd1;
                            end
                        end
                        ST_FLASH: begin
                            if (w_rise[i])
                                r_pending[i] <= 1'b1;
                            if (r_timer[i] == 4'd0) begin
                                r_state[i] <= ST_DW;
                                r_flash[i] <= 1'b0;
                            end else begin
                                r_timer[i] <= r_timer[i] - 4'd1;
                            end
                        end
                        default: begin
                            r_state[i] <= ST_DW;
                            r_walk[i]  <= 1'b0;
                            r_flash[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.walk        = r_walk;
    assign bus.flash_dw    = r_flash;
    assign bus.req_pending = r_pending;
    assign bus.fault       = r_fault;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench: the stimulus side runs a timeline-based reference model and queues
// the expected outputs per cycle; a negedge monitor pops and compares them.
module tb_ped_crossing_ctrl;

    localparam int W = 6;
    localparam int F = 3;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ped_if bus ();

    ped_crossing_ctrl #(.WALK_CYCLES(W), .FLASH_CYCLES(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] walk;
        logic [3:0] flash;
        logic [3:0] pend;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: crosswalk phase is derived from the edge at which it was granted.
    int         n;
    int         start  [4];
    bit         active [4];
    logic [3:0] m_pend;
    bit         m_fault;
    logic [2:0] prev_l [4];
    logic [3:0] ped_hist[$];
    int         lc = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        n        = 0;
        m_pend   = '0;
        m_fault  = 1'b0;
        ped_hist = '{4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 4; i++) begin
            active[i] = 1'b0;
            start[i]  = 0;
            prev_l[i] = RED;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e       = '0;
        e.pend  = m_pend;
        e.fault = m_fault;
        for (int i = 0; i < 4; i++) begin
            if (active[i] && (n - start[i]) < W)
                e.walk[i] = 1'b1;
            else if (active[i] && (n - start[i]) < W + F)
                e.flash[i] = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_edge();
        logic [2:0] l [4];
        logic [3:0] rise;
        logic [3:0] onset;
        bit         det;
        int         nonred;
        bit         busy, in_walk;
        l[0] = bus.light_N;
        l[1] = bus.light_E;
        l[2] = bus.light_S;
        l[3] = bus.light_W;
        n++;
        ped_hist.push_front(bus.ped_req);
        if (ped_hist.size() > 4)
            void'(ped_hist.pop_back());
        // A press becomes a request two sample edges after it is first seen.
        rise   = ped_hist[2] & ~ped_hist[3];
        det    = 1'b0;
        nonred = 0;
        onset  = '0;
        for (int i = 0; i < 4; i++) begin
            if (l[i] != RED && l[i] != YEL && l[i] != GRN) det = 1'b1;
            if (l[i] != RED) nonred++;
            if (active[i] && (n - 1 - start[i]) < W + F && l[i] != RED) det = 1'b1;
            onset[i] = (l[i] == GRN) && (prev_l[i] != GRN);
        end
        if (nonred > 1) det = 1'b1;
        if (m_fault || det) begin
            m_fault = 1'b1;
            m_pend  = '0;
            for (int i = 0; i < 4; i++) active[i] = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                busy    = active[i] && (n - 1 - start[i]) < W + F;
                in_walk = active[i] && (n - 1 - start[i]) < W;
                if (!busy && m_pend[i] && l[i] == RED && (onset & ~(4'b0001 << i)) != 4'b0) begin
                    active[i] = 1'b1;
                    start[i]  = n;
                    m_pend[i] = 1'b0;
                end else if (rise[i] && !in_walk) begin
                    m_pend[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) prev_l[i] = l[i];
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("walk", bus.walk, e.walk);
            check("flash_dw", bus.flash_dw, e.flash);
            check("req_pending", bus.req_pending, e.pend);
            check("fault", {3'b000, bus.fault}, {3'b000, e.fault});
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        exp_q.push_back(model_out());
        #1;
    endtask

    // Upstream controller: N -> E -> S -> W, 11 cycles green then 3 yellow.
    task automatic gen_lights();
        int ph;
        int w;
        logic [2:0] v;
        ph = (lc / 14) % 4;
        w  = lc % 14;
        v  = (w < 11) ? GRN : YEL;
        bus.light_N = (ph == 0) ? v : RED;
        bus.light_E = (ph == 1) ? v : RED;
        bus.light_S = (ph == 2) ? v : RED;
        bus.light_W = (ph == 3) ? v : RED;
        lc++;
    endtask

    task automatic cyc();
        gen_lights();
        tick();
    endtask

    task automatic run(input int k, input int prob);
        logic [3:0] p;
        repeat (k) begin
            p = bus.ped_req;
            if (prob > 0)
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(prob - 1) == 0) p[b] = ~p[b];
            bus.ped_req = p;
            cyc();
        end
    endtask

    // Async reset lands mid-cycle, so this cycle's queued expectation becomes the reset state.
    task automatic assert_reset();
        rst = 1'b1;
        model_reset();
        exp_q[exp_q.size() - 1] = '0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        bus.ped_req = '0;
        bus.light_N = RED;
        bus.light_E = RED;
        bus.light_S = RED;
        bus.light_W = RED;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        // Plain light cycling, no buttons.
        repeat (112) cyc();

        // Crosswalk 0 request during N green, served at E onset.
        bus.ped_req[0] = 1'b1;
        repeat (4) cyc();
        bus.ped_req[0] = 1'b0;
        repeat (40) cyc();

        // Crosswalk 2 request rising right at E onset.
        while (lc % 56 != 12) cyc();
        bus.ped_req[2] = 1'b1;
        repeat (50) cyc();
        bus.ped_req[2] = 1'b0;
        repeat (20) cyc();

        // Random button activity.
        run(600, 12);

        // Reset in the middle of crosswalk 1 FLASH, then normal service again.
        bus.ped_req = '0;
        repeat (4) cyc();
        bus.ped_req[1] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 150 && !found; k++) begin
            cyc();
            if (bus.flash_dw[1]) found = 1'b1;
        end
        check("reach_flash1", {3'b000, found}, 4'b0001);
        assert_reset();
        bus.ped_req = '0;
        repeat (3) cyc();
        bus.ped_req[1] = 1'b1;
        repeat (3) cyc();
        bus.ped_req[1] = 1'b0;
        repeat (80) cyc();

        // Approach N turns green while crosswalk 0 walks.
        bus.ped_req[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 150 && !found; k++) begin
            cyc();
            if (bus.walk[0]) found = 1'b1;
        end
        check("reach_walk0", {3'b000, found}, 4'b0001);
        bus.ped_req[0] = 1'b0;
        gen_lights();
        bus.light_N = GRN;
        tick();
        run(60, 8);

        // Illegal light code for one cycle after a clean reset.
        assert_reset();
        run(30, 10);
        gen_lights();
        bus.light_E = 3'b011;
        tick();
        run(40, 10);

        bus.ped_req = '0;
        repeat (5) cyc();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
